// File: rtl/div_sequencer_if.sv
// div_sequencer_if -- bundle of request/response and shared-ALU signals for div_sequencer.
//
// Handshake: the requester raises start for one cycle while the sequencer is
// idle (busy=0, done=0) to launch one division. Operands, is_signed and sel_rem
// are sampled on that edge. A start seen while busy or while done is high is
// dropped, not queued. Completion is a single-cycle done pulse; result stays
// valid from that pulse until the next accepted start overwrites it. flush
// abandons the operation in flight without a done pulse.
//
// Shared ALU: while alu_req is high the pipeline mux must route alu_op1,
// alu_op2 and alu_ctrl (0=ADD, 1=SUB) to the ALU. alu_result must be the
// combinational ALU output for those operands in the same cycle.
//
// Modports:
//   master : requester plus ALU side (drives start/flush/operands/alu_result)
//   slave  : the sequencer itself
interface div_sequencer_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROLL_WIDTH = 4
);
    logic                      start;
    logic                      flush;
    logic                      is_signed;
    logic                      sel_rem;
    logic [DATA_WIDTH-1:0]     dividend;
    logic [DATA_WIDTH-1:0]     divisor;
    logic                      busy;
    logic                      done;
    logic [DATA_WIDTH-1:0]     result;
    logic                      alu_req;
    logic [DATA_WIDTH-1:0]     alu_op1;
    logic [DATA_WIDTH-1:0]     alu_op2;
    logic [CONTROLL_WIDTH-1:0] alu_ctrl;
    logic [DATA_WIDTH-1:0]     alu_result;

    modport master (
        output start, flush, is_signed, sel_rem, dividend, divisor, alu_result,
        input  busy, done, result, alu_req, alu_op1, alu_op2, alu_ctrl
    );

    modport slave (
        input  start, flush, is_signed, sel_rem, dividend, divisor, alu_result,
        output busy, done, result, alu_req, alu_op1, alu_op2, alu_ctrl
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer -- multi-cycle restoring divider that borrows a shared ALU for
// its subtractions.
//
// An accepted start captures operand magnitudes, then DIVIDE runs one
// restoring step per cycle for DATA_WIDTH cycles. In signed mode a FIXUP
// cycle negates the selected value through the ALU when its sign requires it.
// Divide by zero skips straight to DONE with quotient all-ones and
// remainder equal to the raw dividend.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, highest priority
//   bus        : div_sequencer_if.slave (start/flush/operands, busy/done/result,
//                shared ALU request/operands/result)
//   state_dbg  : current FSM state (0 IDLE, 1 DIVIDE, 2 FIXUP, 3 DONE)
//
// Configuration:
//   DIV_SEQ_SIGNED_EN  defined   -> is_signed selects DIV/REM semantics
//                      undefined -> every division is unsigned, FIXUP unused
module div_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int CONTROLL_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    div_sequencer_if.slave    bus,
    output logic [1:0]        state_dbg
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CONTROLL_WIDTH-1:0] ALU_ADD = '0;
    localparam logic [CONTROLL_WIDTH-1:0] ALU_SUB = CONTROLL_WIDTH'(1);
    localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    // quo starts as the dividend magnitude; each step shifts one dividend bit
    // out of the top and one quotient bit in at the bottom.
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] dvs;
    logic                  neg_q;
    logic                  neg_r;
    logic                  sel_rem_r;
    logic [DATA_WIDTH-1:0] result_r;

    logic                  signed_mode;
    logic                  dvd_neg;
    logic                  dvs_neg;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dvs_mag;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;
    logic                  last;
    logic                  need_fix;
    logic                  take_start;

`ifdef DIV_SEQ_SIGNED_EN
    assign signed_mode = bus.is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
    assign signed_mode      = 1'b0;
`endif

    assign take_start = bus.start && !bus.flush;

    // Negation of the most negative value wraps to itself, which is exactly
    // its unsigned magnitude.
    assign dvd_neg = signed_mode && bus.dividend[DATA_WIDTH-1];
    assign dvs_neg = signed_mode && bus.divisor[DATA_WIDTH-1];
    assign dvd_mag = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign dvs_mag = dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;

    // One restoring step. rem[MSB] set means the shifted partial remainder is
    // really 33 bits wide and therefore always exceeds the divisor; the ALU
    // difference modulo 2^DATA_WIDTH is still the right new remainder.
    assign shifted  = {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
    assign accept   = rem[DATA_WIDTH-1] || (shifted >= dvs);
    assign rem_next = accept ? bus.alu_result : shifted;
    assign quo_next = {quo[DATA_WIDTH-2:0], accept};
    assign last     = (cnt == CNT_LAST);
    assign need_fix = sel_rem_r ? neg_r : neg_q;

    always_comb begin
        state_next   = state;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.alu_req  = 1'b0;
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        bus.alu_ctrl = ALU_ADD;
        case (state)
            S_IDLE: begin
                if (take_start)
                    state_next = (bus.divisor == '0) ? S_DONE : S_DIVIDE;
            end
            S_DIVIDE: begin
                bus.busy     = 1'b1;
                bus.alu_req  = 1'b1;
                bus.alu_op1  = shifted;
                bus.alu_op2  = dvs;
                bus.alu_ctrl = ALU_SUB;
                if (bus.flush)
                    state_next = S_IDLE;
                else if (last)
                    state_next = need_fix ? S_FIXUP : S_DONE;
            end
            S_FIXUP: begin
                bus.busy     = 1'b1;
                bus.alu_req  = 1'b1;
                bus.alu_op1  = '0;
                bus.alu_op2  = sel_rem_r ? rem : quo;
                bus.alu_ctrl = ALU_SUB;
                state_next   = bus.flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // A flush arriving in DONE suppresses the pulse.
                bus.done   = !bus.flush;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            sel_rem_r <= 1'b0;
            result_r  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (take_start) begin
                        sel_rem_r <= bus.sel_rem;
                        neg_q     <= dvd_neg ^ dvs_neg;
                        neg_r     <= dvd_neg;
                        dvs       <= dvs_mag;
                        quo       <= dvd_mag;
                        rem       <= '0;
                        cnt       <= '0;
                        if (bus.divisor == '0)
                            result_r <= bus.sel_rem ? bus.dividend : '1;
                    end
                end
                S_DIVIDE: begin
                    if (!bus.flush) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last && !need_fix)
                            result_r <= sel_rem_r ? rem_next : quo_next;
                    end
                end
                S_FIXUP: begin
                    if (!bus.flush)
                        result_r <= bus.alu_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_r;
    assign state_dbg  = state;
endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int MAX_WAIT = 40;

`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    div_sequencer_if #(.DATA_WIDTH(W), .CONTROLL_WIDTH(CW)) bus ();

    div_sequencer #(.DATA_WIDTH(W), .CONTROLL_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Shared ALU: combinational ADD/SUB.
    always_comb begin
        bus.alu_result = (bus.alu_ctrl == CW'(1)) ? (bus.alu_op1 - bus.alu_op2)
                                                  : (bus.alu_op1 + bus.alu_op2);
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] last_res = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: RISC-V DIV/DIVU/REM/REMU semantics, latency in cycles
    // counted from the cycle start is high to the cycle done is high.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sg, input logic rm, output int lat);
        logic s;
        logic [W-1:0] q, r;
        s = sg && SIGNED_EN;
        if (b == '0) begin
            lat = 1;
            return rm ? a : '1;
        end
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
            lat = (rm ? a[W-1] : (a[W-1] ^ b[W-1])) ? 34 : 33;
        end else begin
            q = a / b;
            r = a % b;
            lat = 33;
        end
        return rm ? r : q;
    endfunction

    // ---------------- driver ----------------
    // Launches one division, optionally pulsing a second start with other
    // operands inj cycles later, then waits for done and scores it.
    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sg, input logic rm, input int inj);
        int n, alu_n, exp_lat, got_done;
        logic seen;
        logic [W-1:0] exp_res;
        @(negedge clk);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sg;
        bus.sel_rem   = rm;
        bus.start     = 1'b1;
        n = 0; alu_n = 0; seen = 1'b0;
        while (!seen && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (inj > 0 && n == inj) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd999;
                bus.divisor  = 32'd10;
                bus.sel_rem  = ~rm;
            end
            if (bus.alu_req) alu_n++;
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        exp_res = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles", name, MAX_WAIT);
            return;
        end
        check({name, " result"}, bus.result, exp_res);
        check_int({name, " latency"}, n, exp_lat);
        check_int({name, " alu_req cycles"}, alu_n, exp_lat - 1);
        @(negedge clk);
        check({name, " done pulse width"}, {31'b0, bus.done}, '0);
        check({name, " result held"}, bus.result, exp_res);
        last_res = exp_res;
        if (inj > 0) begin
            got_done = 0;
            for (int i = 0; i < MAX_WAIT; i++) begin
                @(negedge clk);
                if (bus.done) got_done++;
            end
            check_int({name, " extra done"}, got_done, 0);
            check({name, " result after ignored start"}, bus.result, exp_res);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sg, input logic rm);
        int l;
        logic [W-1:0] e;
        e = ref_model(a, b, sg, rm, l);
        exp_q.push_back(e);
        lat_q.push_back(l);
    endtask

    // Start a division, abort it at DIVIDE cycle 10 by flush or rst.
    task automatic abort_div(input string name, input bit use_rst);
        int got_done;
        @(negedge clk);
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b0;
        bus.sel_rem   = 1'b0;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) @(negedge clk);
        if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.flush = 1'b0;
        check({name, " busy"}, {31'b0, bus.busy}, '0);
        check({name, " alu_req"}, {31'b0, bus.alu_req}, '0);
        check({name, " state"}, {30'b0, state_dbg}, '0);
        if (use_rst) last_res = '0;
        got_done = 0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            if (bus.done) got_done++;
        end
        check_int({name, " done count"}, got_done, 0);
        check({name, " result"}, bus.result, last_res);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sg;
        logic         rm;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sg, input logic rm);
        vec_t v;
        v.a = a; v.b = b; v.sg = sg; v.rm = rm;
        v.exp = ref_model(a, b, sg, rm, v.lat);
        vecs.push_back(v);
    endfunction

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.is_signed = 1'b0;
        bus.sel_rem   = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        add_vec(32'd100,       32'd7,         1'b0, 1'b0);
        add_vec(32'd100,       32'd7,         1'b0, 1'b1);
        add_vec(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0);
        add_vec(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1);
        add_vec(32'd5,         32'd0,         1'b0, 1'b0);
        add_vec(32'd5,         32'd0,         1'b0, 1'b1);
        add_vec(32'd5,         32'd0,         1'b1, 1'b0);
        add_vec(32'd5,         32'd0,         1'b1, 1'b1);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        add_vec(32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);
        add_vec(32'd1,         32'hFFFF_FFFF, 1'b0, 1'b1);
        add_vec(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1);
        add_vec(32'h8000_0000, 32'd3,         1'b1, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        add_vec(32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            add_vec($urandom, (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset busy",    {31'b0, bus.busy},    '0);
        check("reset done",    {31'b0, bus.done},    '0);
        check("reset alu_req", {31'b0, bus.alu_req}, '0);
        check("reset alu_op1", bus.alu_op1,          '0);
        check("reset result",  bus.result,           '0);
        check("reset state",   {30'b0, state_dbg},   '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].exp);
            lat_q.push_back(vecs[i].lat);
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].rm, 0);
        end

        // Start pulsed mid-DIVIDE with other operands must be dropped.
        push_exp(32'd100, 32'd7, 1'b0, 1'b0);
        run_div("ignored start", 32'd100, 32'd7, 1'b0, 1'b0, 5);

        // flush together with start in IDLE: flush wins.
        @(negedge clk);
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush beats start busy",  {31'b0, bus.busy},  '0);
        check("flush beats start state", {30'b0, state_dbg}, '0);

        abort_div("flush mid-divide", 1'b0);
        abort_div("rst mid-divide", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter CONTROLL_WIDTH, default 4, ALU control code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a division; sampled only in IDLE.
REQ-006 flush  input  1  abort the operation in progress.
REQ-007 is_signed  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU.
REQ-008 sel_rem  input  1  1 = return remainder, 0 = return quotient.
REQ-009 dividend, divisor  input  DATA_WIDTH  operands, sampled with start.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  DATA_WIDTH  selected quotient/remainder, held until next accepted start.
REQ-013 alu_req  output  1  block owns the shared ALU this cycle; pipeline mux selects alu_op1/alu_op2/alu_ctrl.
REQ-014 alu_op1, alu_op2  output  DATA_WIDTH  ALU operands.
REQ-015 alu_ctrl  output  CONTROLL_WIDTH  ALU mode; ADD=0, SUB=1.
REQ-016 alu_result  input  DATA_WIDTH  combinational ALU output, same cycle.

Function
REQ-017 States SHALL be IDLE, DIVIDE, FIXUP, DONE.
REQ-018 IDLE: start=1 and flush=0 SHALL capture operands, sel_rem, is_signed; divisor=0 -> DONE, else -> DIVIDE with counter=0.
REQ-019 Capture SHALL store magnitudes: in signed mode negative operands are two's-complement negated (0x80000000 stays 0x80000000 as unsigned magnitude).
REQ-020 DIVIDE SHALL run exactly DATA_WIDTH cycles, 5-bit counter 0..31, leaving after count 31 (no wrap).
REQ-021 Each DIVIDE cycle: shifted = {rem[30:0], next dividend MSB}; alu_op1=shifted, alu_op2=divisor magnitude, alu_ctrl=SUB; accept = rem[31] OR shifted >= divisor (unsigned); accept -> rem<=alu_result, q bit=1; else rem<=shifted, q bit=0.
REQ-022 After DIVIDE: signed mode and selected value needs negation (quotient: operand signs differ; remainder: dividend negative) -> FIXUP, else -> DONE.
REQ-023 FIXUP SHALL drive alu_op1=0, alu_op2=selected value, alu_ctrl=SUB, latch alu_result, -> DONE; one cycle.
REQ-024 alu_req SHALL be 1 exactly in DIVIDE and FIXUP; otherwise alu_op1=alu_op2=0, alu_ctrl=ADD.
REQ-025 Divide by zero SHALL yield quotient 0xFFFFFFFF, remainder = raw dividend, both modes, no FIXUP.
REQ-026 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, through the normal path.
REQ-027 DONE: done=1 for one cycle, then -> IDLE; result remains held.
REQ-028 Latency from start-sampling edge to done high: 33 cycles (no fixup), 34 (fixup), 1 (divisor zero).
REQ-029 start while busy or in DONE SHALL be ignored, not queued.
REQ-030 flush in DIVIDE/FIXUP/DONE SHALL go to IDLE next edge, no done pulse, result unchanged; flush with start in IDLE: flush wins.

Reset
REQ-031 rst=1 at any edge, including mid-DIVIDE, SHALL force IDLE, counter=0, busy=0, done=0, alu_req=0, result=0, internal rem/quotient=0.
REQ-032 rst SHALL take priority over start and flush.

Configuration
REQ-033 Macro DIV_SEQ_SIGNED_EN defined: signed mode per REQ-019/022/023.
REQ-034 Undefined: is_signed ignored, all divisions unsigned, FIXUP unreachable, latency always 33 (1 for zero divisor).

Verification
REQ-035 Unsigned 100/7, sel_rem=0 then 1 -> result 14 then 2, done 33 cycles after start.
REQ-036 Signed -7/2 (0xFFFFFFF9/2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, done at 34 cycles; alu_req high 33 cycles.
REQ-037 5/0 both modes -> quotient 0xFFFFFFFF, remainder 5, done 1 cycle after start, alu_req never high.
REQ-038 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-039 flush at DIVIDE cycle 10 -> busy=0 next cycle, no done, result unchanged; rst at cycle 10 -> result=0.
REQ-040 start pulsed during DIVIDE with other operands -> ignored; first result unchanged, no second done.
